// File: rtl/fp_divider.sv
// fp_divider: sequential IEEE 754 binary32 divider, result = A / B.
// Restoring mantissa divider (25 iterations) under a 4-state FSM; sign,
// exponent and special cases are resolved in a final normalisation cycle.
// Truncating rounding, denormal inputs flushed to zero.
//
// Ports:
//   clk    in   1   clock, rising edge
//   rst    in   1   asynchronous active-high reset
//   start  in   1   request, sampled only in Idle
//   A      in  32   dividend, captured one cycle after start is accepted
//   B      in  32   divisor, captured with A
//   result out 32   registered quotient, updated only at the Norm edge
//   done   out  1   high while Idle (ready, previous result valid)
module fp_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] result,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, LOAD, DIV, NORM} state_t;

    state_t      state, state_nxt;
    logic [31:0] a_q, b_q;
    logic [25:0] r_q;
    logic [24:0] q_q;
    logic [4:0]  cnt_q;

    // Significand of the incoming dividend; zero exponent flushes to zero.
    logic [23:0] ma_in;
    assign ma_in = (A[30:23] != 8'd0) ? {1'b1, A[22:0]} : 24'd0;

    logic [23:0] mb;
    assign mb = (b_q[30:23] != 8'd0) ? {1'b1, b_q[22:0]} : 24'd0;

    // R stays below 2*Mb < 2^25, so the subtraction fits in 25 bits.
    logic        ge;
    logic [24:0] diff;
    assign ge   = (r_q >= {2'b00, mb});
    assign diff = r_q[24:0] - {1'b0, mb};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = LOAD;
            LOAD: state_nxt = DIV;
            DIV:  if (cnt_q == 5'd24) state_nxt = NORM;
            NORM: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        done = (state == IDLE);
    end

    // ---------------- Normalisation / special cases ----------------
    logic       sa, sb, sr;
    logic [7:0] ea, eb;
    logic       a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [9:0] e_calc;
    logic [22:0] frac;
    logic [31:0] res_nxt;

    always_comb begin
        sa     = a_q[31];
        sb     = b_q[31];
        sr     = sa ^ sb;
        ea     = a_q[30:23];
        eb     = b_q[30:23];
        a_nan  = (ea == 8'hFF) && (a_q[22:0] != 23'd0);
        b_nan  = (eb == 8'hFF) && (b_q[22:0] != 23'd0);
        a_inf  = (ea == 8'hFF) && (a_q[22:0] == 23'd0);
        b_inf  = (eb == 8'hFF) && (b_q[22:0] == 23'd0);
        a_zero = (ea == 8'd0);
        b_zero = (eb == 8'd0);
        // 10-bit two's-complement exponent; bit 9 set means negative.
        e_calc = {2'b00, ea} - {2'b00, eb} + (q_q[24] ? 10'd127 : 10'd126);
        frac   = q_q[24] ? q_q[23:1] : q_q[22:0];

        if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero))
            res_nxt = 32'h7FC00000;
        else if (a_inf || b_zero)
            res_nxt = {sr, 8'hFF, 23'd0};
        else if (a_zero || b_inf)
            res_nxt = {sr, 31'd0};
        else if (!e_calc[9] && (e_calc >= 10'd255))
            res_nxt = {sr, 8'hFF, 23'd0};
        else if (e_calc[9] || (e_calc == 10'd0))
            res_nxt = {sr, 31'd0};
        else
            res_nxt = {sr, e_calc[7:0], frac};
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            r_q    <= 26'd0;
            q_q    <= 25'd0;
            cnt_q  <= 5'd0;
            result <= 32'd0;
        end else begin
            case (state)
                LOAD: begin
                    a_q   <= A;
                    b_q   <= B;
                    r_q   <= {2'b00, ma_in};
                    q_q   <= 25'd0;
                    cnt_q <= 5'd0;
                end
                DIV: begin
                    q_q   <= {q_q[23:0], ge};
                    r_q   <= ge ? {diff, 1'b0} : {r_q[24:0], 1'b0};
                    cnt_q <= cnt_q + 5'd1;
                end
                NORM: result <= res_nxt;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_divider.sv
// Self-checking bench for fp_divider: directed spec vectors, back-to-back,
// mid-operation reset, and randomized operands against a reference model
// built from plain integer arithmetic on the IEEE fields.
module tb_fp_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] A, B;
    logic [31:0] result;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    fp_divider dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .A      (A),
        .B      (B),
        .result (result),
        .done   (done)
    );

    always #5 clk = ~clk;

    // Reference: exact quotient of significands, truncated, then the
    // special-case priority list and exponent range limits.
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic        sr;
        int          ea, eb, e;
        longint      ma, mb, q;
        logic [22:0] frac;
        bit a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        sr     = a[31] ^ b[31];
        ea     = int'(a[30:23]);
        eb     = int'(b[30:23]);
        a_nan  = (ea == 255) && (a[22:0] != 0);
        b_nan  = (eb == 255) && (b[22:0] != 0);
        a_inf  = (ea == 255) && (a[22:0] == 0);
        b_inf  = (eb == 255) && (b[22:0] == 0);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) return 32'h7FC00000;
        if (a_inf || b_zero) return {sr, 8'hFF, 23'd0};
        if (a_zero || b_inf) return {sr, 31'd0};
        ma = longint'(a[22:0]) + 64'd8388608;
        mb = longint'(b[22:0]) + 64'd8388608;
        q  = (ma * 64'd16777216) / mb;
        if (q >= 64'd16777216) begin
            e    = ea - eb + 127;
            frac = 23'((q / 2) % 64'd8388608);
        end else begin
            e    = ea - eb + 126;
            frac = 23'(q % 64'd8388608);
        end
        if (e >= 255) return {sr, 8'hFF, 23'd0};
        if (e <= 0)   return {sr, 31'd0};
        return {sr, 8'(e), frac};
    endfunction

    // Issue one operation and wait for completion; reports done-low length.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int low);
        @(negedge clk);
        start = 1'b1; A = a; B = b;
        @(posedge clk); #1;          // edge 0
        start = 1'b0;
        low = 0;
        while (!done && low < 100) begin
            low++;
            @(posedge clk); #1;
        end
        res = result;
    endtask

    task automatic check_op(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_res, input bit check_lat);
        logic [31:0] res;
        int low;
        run_op(a, b, res, low);
        n_vec++;
        if (res !== exp_res) begin
            n_err++;
            $display("FAIL %s: %h / %h got %h expected %h", name, a, b, res, exp_res);
        end
        if (check_lat) begin
            n_vec++;
            if (low !== 27) begin
                n_err++;
                $display("FAIL %s_latency: done low %0d cycles expected 27", name, low);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; A = 32'd0; B = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (result !== 32'd0 || done !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state: result=%h done=%b expected 00000000/1", result, done);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_directed;
        check_op("six_div_two",  32'h40C00000, 32'h40000000, 32'h40400000, 1'b1);
        check_op("one_div_three",32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b1);
        check_op("neg_one_half", 32'hBF800000, 32'h3F000000, 32'hC0000000, 1'b0);
        check_op("one_div_zero", 32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1);
        check_op("zero_div_zero",32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0);
        check_op("inf_div_inf",  32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b0);
        check_op("zero_div_five",32'h00000000, 32'h40A00000, 32'h00000000, 1'b0);
        check_op("overflow",     32'h7F000000, 32'h00800000, 32'h7F800000, 1'b0);
        check_op("underflow",    32'h00800000, 32'h7F000000, 32'h00000000, 1'b0);
        check_op("nan_operand",  32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0);
        check_op("neg_div_inf",  32'hC0000000, 32'h7F800000, 32'h80000000, 1'b0);
    endtask

    task automatic test_back_to_back;
        int low;
        @(negedge clk);
        start = 1'b1; A = 32'hBF800000; B = 32'h3F000000;
        @(posedge clk); #1;          // edge 0, start held high
        @(posedge clk); #1;          // edge 1, operands captured
        A = 32'h3F000000; B = 32'hBF800000;
        low = 1;
        while (!done && low < 100) begin
            low++;
            @(posedge clk); #1;
        end
        n_vec++;
        if (result !== 32'hC0000000) begin
            n_err++;
            $display("FAIL b2b_first: got %h expected c0000000", result);
        end
        @(posedge clk); #1;          // new op edge 0
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_restart: done=%b expected 0", done);
        end
        start = 1'b0;
        low = 0;
        while (!done && low < 100) begin
            low++;
            @(posedge clk); #1;
        end
        n_vec++;
        if (result !== 32'hBF000000 || low !== 27) begin
            n_err++;
            $display("FAIL b2b_second: got %h low=%0d expected bf000000 low=27", result, low);
        end
    endtask

    task automatic test_reset_midop;
        bit stale;
        @(negedge clk);
        start = 1'b1; A = 32'h40C00000; B = 32'h40000000;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_vec++;
        if (done !== 1'b1 || result !== 32'd0) begin
            n_err++;
            $display("FAIL midop_reset: done=%b result=%h expected 1/00000000", done, result);
        end
        @(negedge clk); rst = 1'b0;
        stale = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (result !== 32'd0 || done !== 1'b1) stale = 1'b1;
        end
        n_vec++;
        if (stale) begin
            n_err++;
            $display("FAIL midop_stale: result=%h done=%b expected 00000000/1", result, done);
        end
        check_op("after_reset", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b1);
    endtask

    task automatic test_random;
        logic [31:0] a, b;
        for (int i = 0; i < 60; i++) begin
            a = $urandom;
            b = $urandom;
            // Mostly moderate exponents so the normal path dominates.
            if (i % 4 != 0) begin
                a[30:23] = 8'($urandom_range(60, 190));
                b[30:23] = 8'($urandom_range(60, 190));
            end
            check_op("random", a, b, ref_div(a, b), (i % 10) == 0);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_back_to_back;
        test_reset_midop;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
